// File: rtl/count_pkg.sv
// Shared definitions for the count sequence checker: FSM encoding and
// statistics counter width/saturation limit.
package count_pkg;

    localparam int unsigned STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter; clear takes priority over increment.
module sat_counter
    import count_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/count_seq_checker.sv
// Checks that count_in follows an up-count sequence: acquires lock after
// SYNC_LEN correct increments and drops it after ERR_LIMIT consecutive misses.
module count_seq_checker
    import count_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned SYNC_LEN  = 2,
    parameter int unsigned ERR_LIMIT = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    input  logic             clr,
    output logic             locked,
    output logic             lost_sticky,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0] expected
);

    localparam int unsigned RUN_W  = (SYNC_LEN  < 1) ? 1 : $clog2(SYNC_LEN + 1);
    localparam int unsigned MISS_W = (ERR_LIMIT < 1) ? 1 : $clog2(ERR_LIMIT + 1);

    state_t             state_q,       state_d;
    logic [WIDTH-1:0]   prev_q,        prev_d;
    logic [WIDTH-1:0]   expected_q,    expected_d;
    logic [RUN_W-1:0]   run_len_q,     run_len_d;
    logic [MISS_W-1:0]  miss_run_q,    miss_run_d;
    logic               locked_q,      locked_d;
    logic               lost_sticky_q, lost_sticky_d;
    logic               err_pulse_q;
    logic               wrap_pulse_q;

    logic               match;
    logic               err_inc;
    logic               wrap_inc;

    assign match = (count_in == prev_q + 1'b1);

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        expected_d    = expected_q;
        run_len_d     = run_len_q;
        miss_run_d    = miss_run_q;
        locked_d      = locked_q;
        lost_sticky_d = lost_sticky_q;
        err_inc       = 1'b0;
        wrap_inc      = 1'b0;

        if (count_valid) begin
            prev_d     = count_in;
            expected_d = count_in + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    run_len_d = '0;
                    state_d   = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    run_len_d = match ? run_len_q + 1'b1 : '0;
                    if (run_len_d >= RUN_W'(SYNC_LEN)) begin
                        state_d    = ST_LOCKED;
                        locked_d   = 1'b1;
                        miss_run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        miss_run_d = '0;
                        wrap_inc   = (prev_q == '1);
                    end else begin
                        err_inc    = 1'b1;
                        miss_run_d = miss_run_q + 1'b1;
                        // Too many consecutive misses: fall back and re-acquire.
                        if (miss_run_d >= MISS_W'(ERR_LIMIT)) begin
                            state_d       = ST_ACQUIRE;
                            run_len_d     = '0;
                            miss_run_d    = '0;
                            locked_d      = 1'b0;
                            lost_sticky_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (clr) begin
            lost_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            prev_q        <= '0;
            expected_q    <= '0;
            run_len_q     <= '0;
            miss_run_q    <= '0;
            locked_q      <= 1'b0;
            lost_sticky_q <= 1'b0;
            err_pulse_q   <= 1'b0;
            wrap_pulse_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            expected_q    <= expected_d;
            run_len_q     <= run_len_d;
            miss_run_q    <= miss_run_d;
            locked_q      <= locked_d;
            lost_sticky_q <= lost_sticky_d;
            err_pulse_q   <= err_inc;
            wrap_pulse_q  <= wrap_inc;
        end
    end

    sat_counter u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clr),
        .count (err_count)
    );

    sat_counter u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wrap_inc),
        .clr   (clr),
        .count (wrap_count)
    );

    assign locked      = locked_q;
    assign lost_sticky = lost_sticky_q;
    assign err_pulse   = err_pulse_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign expected    = expected_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed and random checks of count_seq_checker against a behavioural model,
// using a default instance and one with a large error limit.
module tb_count_seq_checker;

    localparam int MOD = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic       count_valid;
    logic       clr;

    logic       d0_locked, d0_lost, d0_errp, d0_wrapp;
    logic [7:0] d0_errc, d0_wrapc;
    logic [3:0] d0_exp;
    logic       d1_locked, d1_lost, d1_errp, d1_wrapp;
    logic [7:0] d1_errc, d1_wrapc;
    logic [3:0] d1_exp;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_seq_checker #(.WIDTH(4), .SYNC_LEN(2), .ERR_LIMIT(3)) dut0 (
        .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
        .clr(clr), .locked(d0_locked), .lost_sticky(d0_lost), .err_pulse(d0_errp),
        .wrap_pulse(d0_wrapp), .err_count(d0_errc), .wrap_count(d0_wrapc),
        .expected(d0_exp)
    );

    count_seq_checker #(.WIDTH(4), .SYNC_LEN(2), .ERR_LIMIT(1000)) dut1 (
        .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
        .clr(clr), .locked(d1_locked), .lost_sticky(d1_lost), .err_pulse(d1_errp),
        .wrap_pulse(d1_wrapp), .err_count(d1_errc), .wrap_count(d1_wrapc),
        .expected(d1_exp)
    );

    // Behavioural view: "have" = a previous sample exists since reset.
    typedef struct {
        bit have, locked, sticky, errp, wrapp;
        int prev, run, miss, errc, wrapc, exp;
    } m_t;

    m_t m0, m1;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic m_t mstep(input m_t m, input int lim, input bit r,
                                 input bit v, input int c, input bit k);
        m_t n;
        bit hit;
        n = m;
        n.errp  = 0;
        n.wrapp = 0;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        if (v) begin
            hit = (c == (m.prev + 1) % MOD);
            if (!m.have) begin
                n.have = 1;
                n.run  = 0;
            end else if (!m.locked) begin
                n.run = hit ? m.run + 1 : 0;
                if (n.run >= 2) begin
                    n.locked = 1;
                    n.miss   = 0;
                end
            end else if (hit) begin
                n.miss = 0;
                if (m.prev == MOD - 1) begin
                    n.wrapp = 1;
                    n.wrapc = sat(m.wrapc + 1);
                end
            end else begin
                n.errp = 1;
                n.errc = sat(m.errc + 1);
                n.miss = m.miss + 1;
                if (n.miss >= lim) begin
                    n.locked = 0;
                    n.run    = 0;
                    n.miss   = 0;
                    n.sticky = 1;
                end
            end
            n.prev = c;
            n.exp  = (c + 1) % MOD;
        end
        if (k) begin
            n.errc   = 0;
            n.wrapc  = 0;
            n.sticky = 0;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("d0.locked",      32'(d0_locked), 32'(m0.locked));
        chk("d0.lost_sticky", 32'(d0_lost),   32'(m0.sticky));
        chk("d0.err_pulse",   32'(d0_errp),   32'(m0.errp));
        chk("d0.wrap_pulse",  32'(d0_wrapp),  32'(m0.wrapp));
        chk("d0.err_count",   32'(d0_errc),   32'(m0.errc));
        chk("d0.wrap_count",  32'(d0_wrapc),  32'(m0.wrapc));
        chk("d0.expected",    32'(d0_exp),    32'(m0.exp));
        chk("d1.locked",      32'(d1_locked), 32'(m1.locked));
        chk("d1.lost_sticky", 32'(d1_lost),   32'(m1.sticky));
        chk("d1.err_pulse",   32'(d1_errp),   32'(m1.errp));
        chk("d1.wrap_pulse",  32'(d1_wrapp),  32'(m1.wrapp));
        chk("d1.err_count",   32'(d1_errc),   32'(m1.errc));
        chk("d1.wrap_count",  32'(d1_wrapc),  32'(m1.wrapc));
        chk("d1.expected",    32'(d1_exp),    32'(m1.exp));
    endtask

    task automatic step(input bit r, input bit v, input int c, input bit k);
        reset       = r;
        count_valid = v;
        count_in    = 4'(c % MOD);
        clr         = k;
        @(posedge clk);
        m0 = mstep(m0, 3, r, v, c % MOD, k);
        m1 = mstep(m1, 1000, r, v, c % MOD, k);
        #1;
        check_all();
    endtask

    initial begin
        int cnt;
        int wraps_seen;
        int seq_a[6];
        int seq_b[9];
        m0 = '{default: 0};
        m1 = '{default: 0};

        // Free-running counter, reset held for two cycles.
        cnt = 0;
        step(1, 1, cnt++, 0);
        step(1, 1, cnt++, 0);
        chk("reset.locked", 32'(d0_locked), 32'd0);
        chk("reset.expected", 32'(d0_exp), 32'd0);
        step(0, 1, cnt++, 0);
        chk("acq.s1.locked", 32'(d0_locked), 32'd0);
        step(0, 1, cnt++, 0);
        chk("acq.s2.locked", 32'(d0_locked), 32'd0);
        step(0, 1, cnt++, 0);
        chk("acq.s3.locked", 32'(d0_locked), 32'd1);
        chk("acq.err_count", 32'(d0_errc), 32'd0);

        wraps_seen = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, cnt++, 0);
            if (d0_wrapp) wraps_seen++;
            chk("run.no_err", 32'(d0_errp), 32'd0);
        end
        chk("run.wrap_pulses", 32'(wraps_seen), 32'd2);
        chk("run.wrap_count", 32'(d0_wrapc), 32'd2);

        // One isolated mismatch keeps lock.
        seq_a = '{2, 3, 4, 9, 10, 11};
        step(1, 0, 0, 0);
        foreach (seq_a[i]) begin
            step(0, 1, seq_a[i], 0);
            if (i == 3) chk("iso.err_pulse", 32'(d0_errp), 32'd1);
        end
        chk("iso.err_count", 32'(d0_errc), 32'd1);
        chk("iso.locked", 32'(d0_locked), 32'd1);

        // Three consecutive mismatches lose lock, then re-acquire.
        seq_b = '{2, 3, 4, 9, 2, 6, 7, 8, 9};
        step(1, 0, 0, 0);
        foreach (seq_b[i]) begin
            step(0, 1, seq_b[i], 0);
            if (i == 5) begin
                chk("loss.locked", 32'(d0_locked), 32'd0);
                chk("loss.sticky", 32'(d0_lost), 32'd1);
                chk("loss.err_count", 32'(d0_errc), 32'd3);
            end
        end
        chk("reacq.locked", 32'(d0_locked), 32'd1);

        // Saturation on the large-limit instance, then clear.
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, i, 0);
        for (int i = 0; i < 300; i++) step(0, 1, (i % 2 == 0) ? 0 : 8, 0);
        chk("sat.err_count", 32'(d1_errc), 32'd255);
        chk("sat.locked", 32'(d1_locked), 32'd1);
        step(0, 1, 0, 0);
        chk("sat.hold", 32'(d1_errc), 32'd255);
        step(0, 0, 0, 1);
        chk("clr.err_count", 32'(d1_errc), 32'd0);
        chk("clr.sticky", 32'(d0_lost), 32'd0);

        // Random traffic: mostly correct increments, occasional glitches and clears.
        cnt = $urandom_range(0, 15);
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit k;
            v = ($urandom_range(0, 3) != 0);
            k = ($urandom_range(0, 49) == 0);
            if (v) cnt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : cnt + 1;
            step(0, v, v ? cnt : int'($urandom_range(0, 15)), k);
        end

        // Reset mid-lock, then idle cycles leave everything unchanged.
        cnt = 0;
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, cnt++, 0);
        chk("midlock.pre", 32'(d0_locked), 32'd1);
        step(1, 1, cnt++, 1);
        chk("midlock.locked", 32'(d0_locked), 32'd0);
        chk("midlock.expected", 32'(d0_exp), 32'd0);
        chk("midlock.err_count", 32'(d1_errc), 32'd0);
        for (int i = 0; i < 5; i++) step(0, 0, $urandom_range(0, 15), 0);
        chk("idle.locked", 32'(d0_locked), 32'd0);
        chk("idle.expected", 32'(d0_exp), 32'd0);
        for (int i = 0; i < 3; i++) step(0, 1, cnt++, 0);
        chk("postreset.locked", 32'(d0_locked), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
